// File: rtl/ct_had_pcfifo_ctrl_pkg.sv
// Shared HAD PC-trace definitions: trace state encoding and FIFO sizing.
package ct_had_pcfifo_ctrl_pkg;

  localparam int HAD_POST_CNT_W = 8;
  localparam int HAD_DEPTH      = 16;
  localparam int HAD_RD_CNT_W   = 5;

  typedef enum logic [1:0] {
    ST_DIS  = 2'b00,
    ST_REC  = 2'b01,
    ST_POST = 2'b10,
    ST_FROZ = 2'b11
  } trace_state_e;

  // The debugger may only pop the FIFO while nothing is being recorded.
  function automatic logic st_rd_allowed(input trace_state_e st);
    return (st == ST_DIS) || (st == ST_FROZ);
  endfunction

endpackage

// File: rtl/ct_had_pcfifo_rdpipe.sv
// Debugger read path: request -> registered pop strobe -> data-valid strobe,
// with outstanding-read tracking, sticky reject flag and saturating read count.
module ct_had_pcfifo_rdpipe
  import ct_had_pcfifo_ctrl_pkg::*;
#(
  parameter int DEPTH = HAD_DEPTH
) (
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  input  logic                    rd_req,
  input  logic                    rd_state_ok,
  input  logic                    flush,
  input  logic                    resume,
  output logic                    ren,
  output logic                    rd_vld,
  output logic                    rd_err,
  output logic [HAD_RD_CNT_W-1:0] rd_cnt
);

  localparam logic [HAD_RD_CNT_W-1:0] CNT_MAX = HAD_RD_CNT_W'(DEPTH);

  logic                    ren_q;
  logic                    vld_q;
  logic                    err_q;
  logic [HAD_RD_CNT_W-1:0] cnt_q;
  logic                    accept;
  logic                    reject;

  // A read sits in its pop cycle (ren_q) while outstanding; a flush cycle
  // silently swallows any request because the trace is being torn down.
  assign accept = rd_req & rd_state_ok & ~ren_q & ~flush;
  assign reject = rd_req & ~flush & ~accept;

  // Pop strobe and data-valid strobe; a flush kills the valid of an in-flight read.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ren_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      ren_q <= accept;
      vld_q <= ren_q & ~flush;
    end
  end

  // Sticky error: a rejection in the same cycle as resume still leaves it set.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      err_q <= 1'b0;
    end else if (reject) begin
      err_q <= 1'b1;
    end else if (resume) begin
      err_q <= 1'b0;
    end
  end

  // Reads since last freeze, counted on the pop cycle and saturating at DEPTH.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_q <= '0;
    end else if (resume) begin
      cnt_q <= '0;
    end else if (ren_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ren    = ren_q;
  assign rd_vld = vld_q;
  assign rd_err = err_q;
  assign rd_cnt = cnt_q;

endmodule

// File: rtl/ct_had_pcfifo_ctrl.sv
// PC-trace control ahead of the HAD PC FIFO: trace-mode FSM with post-trigger
// countdown, record enable generation, and the debugger read pipeline.
module ct_had_pcfifo_ctrl
  import ct_had_pcfifo_ctrl_pkg::*;
#(
  parameter int POST_CNT_W = HAD_POST_CNT_W,
  parameter int DEPTH      = HAD_DEPTH
) (
  input  logic                    cpuclk,
  input  logic                    cpurst_b,
  input  logic                    regs_pcfifo_en,
  input  logic [POST_CNT_W-1:0]   regs_pcfifo_post_cnt,
  input  logic                    regs_pcfifo_resume,
  input  logic                    regs_pcfifo_rd_req,
  input  logic                    had_trig_hit,
  input  logic                    had_dbg_mode,
  input  logic [3:0]              rtu_had_xx_pcfifo_inst_chgflow,
  output logic                    ctrl_pcfifo_wen,
  output logic                    ctrl_pcfifo_ren,
  output logic                    ctrl_regs_rd_vld,
  output logic                    ctrl_regs_rd_err,
  output logic [1:0]              ctrl_regs_state,
  output logic [HAD_RD_CNT_W-1:0] ctrl_regs_rd_cnt
);

  trace_state_e          state_q;
  logic [POST_CNT_W-1:0] post_cnt_q;
  logic                  recording;
  logic                  flush;
  logic                  resume_eff;

  assign recording  = (state_q == ST_REC) || (state_q == ST_POST);
  // The FIFO flops wen together with chgflow, so it is left combinational.
  assign ctrl_pcfifo_wen = recording & ~had_dbg_mode & (|rtu_had_xx_pcfifo_inst_chgflow);
  assign flush      = ~regs_pcfifo_en & (state_q != ST_DIS);
  assign resume_eff = regs_pcfifo_en & (state_q == ST_FROZ) & regs_pcfifo_resume;

  // Trace-mode FSM and post-trigger write countdown; disable overrides everything.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_DIS;
      post_cnt_q <= '0;
    end else if (!regs_pcfifo_en) begin
      state_q    <= ST_DIS;
    end else begin
      case (state_q)
        ST_DIS: begin
          state_q <= ST_REC;
        end
        ST_REC: begin
          if (had_dbg_mode) begin
            state_q <= ST_FROZ;
          end else if (had_trig_hit) begin
            if (regs_pcfifo_post_cnt == '0) begin
              state_q <= ST_FROZ;
            end else begin
              state_q    <= ST_POST;
              post_cnt_q <= regs_pcfifo_post_cnt;
            end
          end
        end
        ST_POST: begin
          if (had_dbg_mode) begin
            state_q <= ST_FROZ;
          end else if (ctrl_pcfifo_wen) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == POST_CNT_W'(1)) begin
              state_q <= ST_FROZ;
            end
          end
        end
        ST_FROZ: begin
          if (regs_pcfifo_resume) begin
            state_q <= ST_REC;
          end
        end
        default: begin
          state_q <= ST_DIS;
        end
      endcase
    end
  end

  assign ctrl_regs_state = state_q;

  ct_had_pcfifo_rdpipe #(
    .DEPTH (DEPTH)
  ) u_rdpipe (
    .cpuclk      (cpuclk),
    .cpurst_b    (cpurst_b),
    .rd_req      (regs_pcfifo_rd_req),
    .rd_state_ok (st_rd_allowed(state_q) & ~resume_eff),
    .flush       (flush),
    .resume      (resume_eff),
    .ren         (ctrl_pcfifo_ren),
    .rd_vld      (ctrl_regs_rd_vld),
    .rd_err      (ctrl_regs_rd_err),
    .rd_cnt      (ctrl_regs_rd_cnt)
  );

endmodule

// File: tb/tb_ct_had_pcfifo_ctrl.sv
// Bench for ct_had_pcfifo_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ct_had_pcfifo_ctrl;

  logic       cpuclk;
  logic       cpurst_b;
  logic       en;
  logic [7:0] post;
  logic       resume;
  logic       rd_req;
  logic       trig;
  logic       dbg;
  logic [3:0] chg;
  logic       wen;
  logic       ren;
  logic       rd_vld;
  logic       rd_err;
  logic [1:0] state;
  logic [4:0] rd_cnt;

  ct_had_pcfifo_ctrl dut (
    .cpuclk                         (cpuclk),
    .cpurst_b                       (cpurst_b),
    .regs_pcfifo_en                 (en),
    .regs_pcfifo_post_cnt           (post),
    .regs_pcfifo_resume             (resume),
    .regs_pcfifo_rd_req             (rd_req),
    .had_trig_hit                   (trig),
    .had_dbg_mode                   (dbg),
    .rtu_had_xx_pcfifo_inst_chgflow (chg),
    .ctrl_pcfifo_wen                (wen),
    .ctrl_pcfifo_ren                (ren),
    .ctrl_regs_rd_vld               (rd_vld),
    .ctrl_regs_rd_err               (rd_err),
    .ctrl_regs_state                (state),
    .ctrl_regs_rd_cnt               (rd_cnt)
  );

  initial cpuclk = 1'b0;
  always #5 cpuclk = ~cpuclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode as a small integer, remaining post-trigger writes,
  // and a list of cycle numbers at which reads were accepted.
  localparam int M_DIS = 0, M_REC = 1, M_POST = 2, M_FROZ = 3;
  int m_mode  = M_DIS;
  int m_rem   = 0;
  int m_reads = 0;
  bit m_err   = 0;
  int acc_q[$];
  int cyc     = 0;

  logic       snap_wen, snap_ren, snap_vld, snap_err;
  logic [1:0] snap_state;
  logic [4:0] snap_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: compare DUT with model, advance model, then release pulses.
  task automatic tick();
    bit e_wen, e_ren, e_vld, flush, res_eff, busy, rej;
    int new_q[$];
    #1;
    snap_wen = wen; snap_ren = ren; snap_vld = rd_vld;
    snap_err = rd_err; snap_state = state; snap_cnt = rd_cnt;
    e_wen = ((m_mode == M_REC) || (m_mode == M_POST)) && !dbg && (chg != 4'd0);
    e_ren = 0; e_vld = 0;
    foreach (acc_q[i]) begin
      if (acc_q[i] == cyc - 1) e_ren = 1;
      if (acc_q[i] == cyc - 2) e_vld = 1;
    end
    busy = e_ren;
    chk("wen", {7'd0, wen}, {7'd0, e_wen});
    chk("ren", {7'd0, ren}, {7'd0, e_ren});
    chk("rd_vld", {7'd0, rd_vld}, {7'd0, e_vld});
    chk("rd_err", {7'd0, rd_err}, {7'd0, m_err});
    chk("state", {6'd0, state}, 8'(m_mode));
    chk("rd_cnt", {3'd0, rd_cnt}, 8'(m_reads));
    $display("cyc=%0d en=%0b trig=%0b dbg=%0b chg=%h req=%0b res=%0b | st=%0d wen=%0b ren=%0b vld=%0b err=%0b cnt=%0d",
             cyc, en, trig, dbg, chg, rd_req, resume, state, wen, ren, rd_vld, rd_err, rd_cnt);
    flush   = !en && (m_mode != M_DIS);
    res_eff = en && (m_mode == M_FROZ) && resume;
    rej = 0;
    // read acceptance
    if (rd_req && !flush) begin
      if ((m_mode == M_FROZ || m_mode == M_DIS) && !busy && !res_eff) acc_q.push_back(cyc);
      else rej = 1;
    end
    if (rej) m_err = 1;
    else if (res_eff) m_err = 0;
    if (res_eff) m_reads = 0;
    else if (e_ren && m_reads < 16) m_reads++;
    // drop reads whose valid would fall after the teardown, and stale entries
    foreach (acc_q[i]) begin
      if (!(flush && acc_q[i] >= cyc - 1) && acc_q[i] >= cyc - 1) new_q.push_back(acc_q[i]);
    end
    acc_q = new_q;
    // mode transitions
    if (!en) m_mode = M_DIS;
    else if (m_mode == M_DIS) m_mode = M_REC;
    else if (m_mode == M_REC) begin
      if (dbg || (trig && post == 0)) m_mode = M_FROZ;
      else if (trig) begin m_mode = M_POST; m_rem = int'(post); end
    end else if (m_mode == M_POST) begin
      if (dbg) m_mode = M_FROZ;
      else if (e_wen) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_mode = M_FROZ;
      end
    end else if (resume) m_mode = M_REC;
    cyc++;
    @(negedge cpuclk);
    resume = 0; rd_req = 0; trig = 0; chg = 4'd0;
  endtask

  int ren_seen;

  initial begin
    cpurst_b = 0; en = 0; post = 8'd0; resume = 0; rd_req = 0;
    trig = 0; dbg = 0; chg = 4'd0;
    @(negedge cpuclk);
    @(negedge cpuclk);
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_outs", {3'd0, wen, ren, rd_vld, rd_err, 1'b0}, 8'd0);
    chk("rst_cnt", {3'd0, rd_cnt}, 8'd0);
    cpurst_b = 1;

    // enable, record a chgflow, then disable
    en = 1; tick();
    chg = 4'b0101; tick();
    chk("s1_wen", {7'd0, snap_wen}, 8'd1);
    chk("s1_state", {6'd0, snap_state}, 8'd1);
    en = 0; tick();
    chg = 4'b0101; tick();
    chk("s1_dis_state", {6'd0, snap_state}, 8'd0);
    chk("s1_dis_wen", {7'd0, snap_wen}, 8'd0);

    // trigger with post count 3, writes spaced by idle cycles
    en = 1; post = 8'd3; tick();
    trig = 1; chg = 4'b0001; tick();
    chk("s2_trig_wen", {7'd0, snap_wen}, 8'd1);
    trig = 1; tick();
    chk("s2_post", {6'd0, snap_state}, 8'd2);
    chg = 4'b0001; tick();
    tick();
    chg = 4'b0010; tick();
    tick();
    chk("s2_still_post", {6'd0, snap_state}, 8'd2);
    chg = 4'b1000; tick();
    chk("s2_last_wen", {7'd0, snap_wen}, 8'd1);
    tick();
    chk("s2_froz", {6'd0, snap_state}, 8'd3);

    // debug mode while recording freezes and suppresses the write
    resume = 1; tick();
    tick();
    dbg = 1; chg = 4'b1111; tick();
    chk("s3_dbg_wen", {7'd0, snap_wen}, 8'd0);
    dbg = 0; tick();
    chk("s3_froz", {6'd0, snap_state}, 8'd3);

    // single read latency, then saturating read count
    rd_req = 1; tick();
    chk("s4_no_ren_T", {7'd0, snap_ren}, 8'd0);
    tick();
    chk("s4_ren_T1", {7'd0, snap_ren}, 8'd1);
    tick();
    chk("s4_vld_T2", {7'd0, snap_vld}, 8'd1);
    chk("s4_ren_T2", {7'd0, snap_ren}, 8'd0);
    chk("s4_cnt1", {3'd0, snap_cnt}, 8'd1);
    for (int i = 0; i < 17; i++) begin
      rd_req = 1; tick();
      tick(); tick(); tick();
    end
    chk("s4_cnt_sat", {3'd0, snap_cnt}, 8'd16);

    // back-to-back requests: second rejected, then resume clears
    ren_seen = 0;
    rd_req = 1; tick(); ren_seen += int'(snap_ren);
    rd_req = 1; tick(); ren_seen += int'(snap_ren);
    tick(); ren_seen += int'(snap_ren);
    chk("s5_err", {7'd0, snap_err}, 8'd1);
    tick(); ren_seen += int'(snap_ren);
    chk("s5_single_ren", 8'(ren_seen), 8'd1);
    resume = 1; tick();
    tick();
    chk("s5_res_err", {7'd0, snap_err}, 8'd0);
    chk("s5_res_cnt", {3'd0, snap_cnt}, 8'd0);
    chk("s5_res_state", {6'd0, snap_state}, 8'd1);

    // read while recording is rejected; in-flight read aborted by disable
    rd_req = 1; tick();
    tick();
    chk("s6_rec_ren", {7'd0, snap_ren}, 8'd0);
    chk("s6_rec_err", {7'd0, snap_err}, 8'd1);
    dbg = 1; tick();
    dbg = 0; rd_req = 1; tick();
    en = 0; tick();
    tick();
    chk("s6_abort_vld", {7'd0, snap_vld}, 8'd0);
    chk("s6_abort_state", {6'd0, snap_state}, 8'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 39) != 0);
      dbg    = ($urandom_range(0, 19) == 0);
      trig   = ($urandom_range(0, 7) == 0);
      resume = ($urandom_range(0, 9) == 0);
      rd_req = ($urandom_range(0, 2) == 0);
      chg    = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'd0;
      post   = 8'($urandom_range(0, 4));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
